// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants.
// Holds the receiver state encoding and the default oversample ratio.
package uart_pkg;

    localparam int UART_OVERSAMPLE_DEFAULT = 16;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t S_IDLE   = 3'd0;
    localparam rx_state_t S_START  = 3'd1;
    localparam rx_state_t S_DATA   = 3'd2;
    localparam rx_state_t S_PARITY = 3'd3;
    localparam rx_state_t S_STOP   = 3'd4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Ports: clk, reset (sync, active-high), d_i async in, q_o synced out.
// Both flops reset high so a reset never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, 8 data bits, LSB first, one stop bit.
// Ports: clk, reset (sync, active-high), rx_en tick, rx_data line;
//   data_out/valid, busy, frame_err, parity_err pulses.
// Define UART_RX_PARITY_EN to add an even parity bit before stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       rx_data,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

    logic rx_s;

    rx_state_t     state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          prev_q;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          perr_q, perr_d;
    logic          par_bad;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx_data),
        .q_o   (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;

    always_ff @(posedge clk) begin
        if (reset) par_q <= 1'b0;
        else       par_q <= par_d;
    end

    assign par_bad = par_q;
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                // Edge only: a line held low (break) cannot restart
                if (prev_q && !rx_s) begin
                    state_d = S_START;
                    tick_d  = '0;
                end
            end
            S_START: begin
                if (rx_en) begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d = S_DATA;
                            idx_d   = 3'd0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (rx_en) begin
                    if (tick_q == TICK_END) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        idx_d   = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (rx_en) begin
                    if (tick_q == TICK_END) begin
                        tick_d  = '0;
                        par_d   = ^{shift_q, rx_s};
                        state_d = S_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (rx_en) begin
                    if (tick_q == TICK_END) begin
                        tick_d  = '0;
                        state_d = S_IDLE;
                        ferr_d  = !rx_s;
                        perr_d  = par_bad;
                        if (rx_s && !par_bad) begin
                            valid_d = 1'b1;
                            data_d  = shift_q;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            prev_q  <= 1'b1;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            prev_q  <= rx_s;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at OVERSAMPLE=16 with rx_en tied high.
// Define UART_RX_PARITY_EN to run the parity frames as well.
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       rx_en;
    logic       rx_data;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    int total;
    int bad;
    int nvalid;
    int nferr;
    int nperr;
    logic [7:0] rxq[$];

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_en      (rx_en),
        .rx_data    (rx_data),
        .data_out   (data_out),
        .valid      (valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            nvalid++;
            rxq.push_back(data_out);
        end
        if (frame_err)  nferr++;
        if (parity_err) nperr++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_data = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_data = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic pflip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ pflip);
`else
        if (pflip) rx_data = 1'b1;
`endif
        drive_bit(stop);
    endtask

    int v0, f0, p0, qb;
    logic [7:0] q0, q1;

    initial begin
        total   = 0;
        bad     = 0;
        nvalid  = 0;
        nferr   = 0;
        nperr   = 0;
        reset   = 1'b1;
        rx_en   = 1'b1;
        rx_data = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_data",  {24'd0, data_out}, 32'h00);
        check("rst_valid", {31'd0, valid},      32'd0);
        check("rst_busy",  {31'd0, busy},       32'd0);
        check("rst_ferr",  {31'd0, frame_err},  32'd0);
        check("rst_perr",  {31'd0, parity_err}, 32'd0);

        reset = 1'b0;
        idle(10);

        // Plain frame
        v0 = nvalid; f0 = nferr; p0 = nperr;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);
        check("a5_nvalid", nvalid - v0, 1);
        check("a5_data",   {24'd0, data_out}, 32'hA5);
        check("a5_ferr",   nferr - f0, 0);
        check("a5_perr",   nperr - p0, 0);

        // Short low glitch must be rejected as a false start
        v0 = nvalid; f0 = nferr;
        rx_data = 1'b0;
        repeat (4) @(negedge clk);
        rx_data = 1'b1;
        repeat (2) @(negedge clk);
        check("gl_busy_hi", {31'd0, busy}, 32'd1);
        repeat (8) @(negedge clk);
        check("gl_busy_lo", {31'd0, busy}, 32'd0);
        idle(20);
        check("gl_nvalid", nvalid - v0, 0);
        check("gl_errs",   (nferr - f0) + (nperr - p0), 0);

        // Bad stop bit
        v0 = nvalid; f0 = nferr;
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(30);
        check("fe_ferr",   nferr - f0, 1);
        check("fe_nvalid", nvalid - v0, 0);
        check("fe_data",   {24'd0, data_out}, 32'hA5);

        // Back-to-back frames with no idle gap
        v0 = nvalid; qb = rxq.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(20);
        q0 = (rxq.size() > qb)     ? rxq[qb]     : 8'hxx;
        q1 = (rxq.size() > qb + 1) ? rxq[qb + 1] : 8'hxx;
        check("bb_nvalid", nvalid - v0, 2);
        check("bb_first",  {24'd0, q0}, 32'h00);
        check("bb_second", {24'd0, q1}, 32'hFF);

        // Reset in the middle of bit 4, then a clean frame
        v0 = nvalid; f0 = nferr; p0 = nperr;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
        rx_data = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(200);
        check("mr_nvalid", nvalid - v0, 0);
        check("mr_data",   {24'd0, data_out}, 32'h00);
        check("mr_busy",   {31'd0, busy}, 32'd0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(20);
        check("mr_nvalid2", nvalid - v0, 1);
        check("mr_data2",   {24'd0, data_out}, 32'h81);
        check("mr_errs",    (nferr - f0) + (nperr - p0), 0);

`ifdef UART_RX_PARITY_EN
        // Wrong parity, then correct parity, for 0x07 (three ones)
        v0 = nvalid; p0 = nperr;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
        check("pe_perr",   nperr - p0, 1);
        check("pe_nvalid", nvalid - v0, 0);
        check("pe_data",   {24'd0, data_out}, 32'h81);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(20);
        check("po_nvalid", nvalid - v0, 1);
        check("po_data",   {24'd0, data_out}, 32'h07);
        check("po_perr",   nperr - p0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, number of rx_en ticks per bit period; even, >= 4.
REQ-002 clk  input  1  clock; all logic on posedge clk.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 rx_en  input  1  oversample tick; counters advance only in cycles where rx_en=1.
REQ-005 rx_data  input  1  asynchronous serial line, idle high.
REQ-006 data_out  output  8  last correctly received byte; held until the next valid frame.
REQ-007 valid  output  1  one-cycle pulse when data_out updates.
REQ-008 busy  output  1  high whenever state != IDLE (combinational).
REQ-009 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 without UART_RX_PARITY_EN.

Function
REQ-011 rx_data SHALL pass through a 2-flop synchronizer (rx_s) before any use; line latency 2 clk.
REQ-012 States: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-013 IDLE: start detected only on a falling edge of rx_s (prior cycle 1, current 0), regardless of rx_en; go START with tick counter cleared.
REQ-014 START: at tick count OVERSAMPLE/2-1, rx_s=0 -> DATA (tick cnt 0, bit idx 0); rx_s=1 -> IDLE, no flags (false start).
REQ-015 DATA: sample rx_s at tick count OVERSAMPLE-1 into shift reg bit idx, LSB first; after bit 7 -> PARITY if compiled in, else STOP.
REQ-016 PARITY: sample at tick count OVERSAMPLE-1; even parity over the 8 data bits plus the parity bit; then STOP.
REQ-017 STOP: sample at tick count OVERSAMPLE-1, then return to IDLE in the same transition (enables back-to-back frames).
REQ-018 Stop=1 and no parity error -> data_out <= shift reg and valid=1 in the clk cycle after the sample.
REQ-019 Stop=0 -> frame_err pulse in that cycle; no valid; data_out unchanged.
REQ-020 Parity error -> parity_err pulse in that cycle; no valid; data_out unchanged; frame_err and parity_err may pulse together.
REQ-021 Tick counter width SHALL be $clog2(OVERSAMPLE); no wrap except reload to 0 at bit boundary.
REQ-022 After a frame error with the line held low (break), no new frame starts until rx_s returns high and falls again.

Reset
REQ-023 Reset: state=IDLE, data_out=8'h00, valid=0, frame_err=0, parity_err=0, synchronizer flops=1, counters=0.
REQ-024 Reset mid-frame SHALL discard the partial frame; no valid or error pulse produced.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: 11-bit frame (start, 8 data, even parity, stop), PARITY state and parity_err active.
REQ-026 UART_RX_PARITY_EN undefined: 10-bit frame, no PARITY state, parity_err tied 0.

Structure
REQ-027 Package uart_pkg SHALL hold typedef rx_state_t and constant UART_OVERSAMPLE_DEFAULT=16.
REQ-028 Sub-module uart_rx_sync (2-flop synchronizer, reset value 1) SHALL be instantiated for rx_data.

Verification (OVERSAMPLE=16, rx_en tied 1, macro undefined unless noted)
REQ-029 Frame 0xA5, 16 clk/bit -> exactly one valid pulse, data_out=8'hA5, no error pulses.
REQ-030 Low glitch of 4 clk on idle line -> return to IDLE, no valid, no errors, busy drops within 12 clk.
REQ-031 Frame 0x3C with stop bit low -> frame_err pulse, no valid, data_out keeps previous value.
REQ-032 Back-to-back frames 0x00 then 0xFF with no idle gap -> two valid pulses, values 8'h00 then 8'hFF.
REQ-033 Reset asserted during bit 4 of frame 0x55, then frame 0x81 -> only valid with data_out=8'h81.
REQ-034 Macro defined, frame 0x07 with parity bit 0 (wrong) -> parity_err pulse, no valid; parity 1 -> valid, data_out=8'h07.
